// File: rtl/v60_prefetch_queue_if.sv
// Memory-side bus of the V60 prefetch queue: aligned word reads with a req/ready handshake.
interface v60_prefetch_queue_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_wr;
    logic [1:0]            mem_size;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_wr, mem_size, mem_addr,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_wr, mem_size, mem_addr,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/v60_prefetch_queue.sv
// V60 instruction prefetch queue: fetches aligned words into a byte ring buffer and
// presents an 8-byte decode window starting at the current instruction address.
module v60_prefetch_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   flush_addr,
    input  logic [3:0]              consume,
    v60_prefetch_queue_if.master    mem,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic [63:0]             q_data,
    output logic [ADDR_WIDTH-1:0]   q_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } bus_state_e;

    bus_state_e            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] q_pc_q, q_pc_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            skip_q, skip_d;
    logic                  drop_q, drop_d;

    logic [7:0]            ram_q [DEPTH];
    logic                  wr_en;
    logic [2:0]            wr_len;
    logic [CW:0]           free_space;
    logic [7:0]            lane_byte [4];
    logic [7:0]            wr_byte [4];

    // Lane k carries the byte at fetch_addr+k (big-end lane first on the bus).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_byte[k] = mem.mem_rdata[31-8*k -: 8];
        end
        for (int j = 0; j < 4; j++) begin
            wr_byte[j] = lane_byte[2'(j) + skip_q];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        drop_d       = drop_q;
        wr_en        = 1'b0;
        wr_len       = 3'd4 - {1'b0, skip_q};
        free_space   = (CW+1)'(DEPTH) - {1'b0, count_q};
        rd_ptr_d     = rd_ptr_q + PW'(consume);
        q_pc_d       = q_pc_q + ADDR_WIDTH'(consume);

        unique case (state_q)
            ST_IDLE: begin
                if (fetch_en && !flush && free_space >= (CW+1)'(4)) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_addr_q;
                end
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    state_d   = ST_GAP;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_q && !flush) begin
                        wr_en        = 1'b1;
                        skip_d       = 2'd0;
                        fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
                    end
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + PW'(wr_len) : wr_ptr_q;
        count_d  = count_q - CW'(consume) + (wr_en ? CW'(wr_len) : CW'(0));

        // A redirect empties the queue but lets an in-flight read finish on the bus.
        if (flush) begin
            count_d      = '0;
            rd_ptr_d     = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q;
            q_pc_d       = flush_addr;
            fetch_addr_d = {flush_addr[ADDR_WIDTH-1:2], 2'b00};
            skip_d       = flush_addr[1:0];
            drop_d       = (state_q == ST_REQ) && !mem.mem_ready;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            fetch_addr_q <= '0;
            q_pc_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            skip_q       <= 2'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            fetch_addr_q <= fetch_addr_d;
            q_pc_q       <= q_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            skip_q       <= skip_d;
            drop_q       <= drop_d;
        end
    end

    // NOTE: the byte store is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < wr_len) begin
                    ram_q[wr_ptr_q + PW'(j)] <= wr_byte[j];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            q_data[8*k +: 8] = ram_q[rd_ptr_q + PW'(k)];
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_wr   = 1'b0;
    assign mem.mem_size = 2'b10;
    assign q_count      = count_q;
    assign q_pc         = q_pc_q;
endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Self-checking bench for v60_prefetch_queue: directed scenarios plus random traffic
// compared against a byte-queue reference model driven by observed bus completions.
module tb_v60_prefetch_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_addr = '0;
    logic [3:0]    consume = '0;
    logic [CW-1:0] q_count;
    logic [63:0]   q_data;
    logic [AW-1:0] q_pc;

    v60_prefetch_queue_if #(.ADDR_WIDTH(AW)) bus ();

    v60_prefetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .flush_addr (flush_addr),
        .consume    (consume),
        .mem        (bus),
        .q_count    (q_count),
        .q_data     (q_data),
        .q_pc       (q_pc)
    );

    always #5 clk = ~clk;

    // Memory image: fixed bytes at the bottom, a scrambled pattern elsewhere.
    logic [7:0] rom_lo [16] = '{8'hB8, 8'h34, 8'h12, 8'h00, 8'h7E, 8'hB9, 8'h2D, 8'h44,
                                8'h90, 8'h0F, 8'h01, 8'hC1, 8'h5A, 8'h66, 8'hE3, 8'h81};

    function automatic logic [7:0] mem_byte(logic [AW-1:0] a);
        if (a < 32'd16) return rom_lo[a[3:0]];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(logic [AW-1:0] a);
        return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
    endfunction

    // Memory responder: ready after lat request cycles; optional junk ready while idle.
    int lat      = 1;
    bit junk_en  = 1'b0;
    int wait_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            wait_cnt      = 0;
        end else if (bus.mem_req) begin
            if (wait_cnt >= lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
            end else begin
                bus.mem_ready = 1'b0;
            end
            wait_cnt++;
        end else begin
            wait_cnt      = 0;
            bus.mem_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    // Reference model: the queue as a list of bytes, plus fetch bookkeeping.
    logic [7:0]    mq [$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_fetch;
    logic [1:0]    m_skip;
    bit            m_stale;
    bit            m_gap;
    logic [AW-1:0] issues [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pc    = '0;
        m_fetch = '0;
        m_skip  = 2'd0;
        m_stale = 1'b0;
        m_gap   = 1'b0;
    endtask

    task automatic compare_all(bit exp_req, logic [AW-1:0] exp_addr);
        logic [63:0] exp_w;
        logic [63:0] mask;
        int n;
        check("q_count", 64'(q_count), 64'(mq.size()));
        check("q_pc", 64'(q_pc), 64'(m_pc));
        n     = (mq.size() < 8) ? mq.size() : 8;
        exp_w = '0;
        mask  = '0;
        for (int k = 0; k < n; k++) begin
            exp_w[8*k +: 8] = mq[k];
            mask[8*k +: 8]  = 8'hFF;
        end
        check("q_data", q_data & mask, exp_w);
        check("mem_req", 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    endtask

    // One clock: drive inputs, predict the edge from the rules, compare after it.
    task automatic step(bit fl, logic [AW-1:0] fa, int cons);
        bit            p_req, p_rdy, done, exp_req;
        logic [AW-1:0] p_addr;
        int            cnt0;
        @(negedge clk);
        flush      = fl;
        flush_addr = fa;
        consume    = 4'(cons);
        #2;
        p_req  = bus.mem_req;
        p_rdy  = bus.mem_ready;
        p_addr = bus.mem_addr;
        cnt0   = mq.size();
        done   = p_req && p_rdy;
        @(posedge clk);
        if (done)       exp_req = 1'b0;
        else if (p_req) exp_req = 1'b1;
        else if (m_gap) exp_req = 1'b0;
        else            exp_req = fetch_en && !fl && (DEPTH - cnt0 >= 4);
        m_gap = done;
        if (fl) begin
            mq.delete();
            m_pc    = fa;
            m_fetch = {fa[AW-1:2], 2'b00};
            m_skip  = fa[1:0];
            m_stale = p_req && !p_rdy;
        end else begin
            repeat (cons) void'(mq.pop_front());
            m_pc = m_pc + AW'(cons);
            if (done) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    check("fetch_addr", 64'(p_addr), 64'(m_fetch));
                    for (int k = int'(m_skip); k < 4; k++) mq.push_back(mem_byte(p_addr + AW'(k)));
                    m_fetch = m_fetch + 32'd4;
                    m_skip  = 2'd0;
                end
            end
        end
        #1;
        if (!p_req && bus.mem_req) issues.push_back(bus.mem_addr);
        compare_all(exp_req, p_req ? p_addr : m_fetch);
    endtask

    task automatic idle_step();
        step(1'b0, '0, 0);
    endtask

    initial begin
        bit seen;
        int lim;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
        check("rst_mem_size", 64'(bus.mem_size), 64'(2));
        check("rst_q_count", 64'(q_count), 64'(0));
        check("rst_q_pc", 64'(q_pc), 64'(0));

        // Fill from reset with no consumption: four words, then the queue is full.
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        lat      = 1;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            idle_step();
            if (!seen && q_count == CW'(4)) begin
                seen = 1'b1;
                check("first_q_data", 64'(q_data[15:0]), 64'(16'h34B8));
                check("first_q_pc", 64'(q_pc), 64'(0));
            end
        end
        check("first_seen", 64'(seen), 64'(1));
        check("fill_count", 64'(q_count), 64'(16));
        check("fill_issues", 64'(issues.size()), 64'(4));
        for (int i = 0; i < 4 && i < issues.size(); i++) check("fill_addr", 64'(issues[i]), 64'(4 * i));

        step(1'b0, '0, 5);
        check("c5_count", 64'(q_count), 64'(11));
        check("c5_pc", 64'(q_pc), 64'(5));
        check("c5_byte", 64'(q_data[7:0]), 64'(8'hB9));

        // Redirect while the word at 0x04 is outstanding.
        step(1'b1, 32'h0, 0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            idle_step();
            seen = bus.mem_req && (bus.mem_addr == 32'h4);
        end
        check("flush_setup", 64'(seen), 64'(1));
        step(1'b1, 32'h0A, 0);
        issues.delete();
        for (int i = 0; i < 30 && q_count == '0; i++) idle_step();
        check("fl_count", 64'(q_count), 64'(2));
        check("fl_pc", 64'(q_pc), 64'(32'h0A));
        check("fl_data", 64'(q_data[15:0]), 64'(16'hC101));
        check("fl_next_addr", 64'(issues.size() > 0 ? issues[0] : '1), 64'(32'h8));

        // Completion and consume=2 land on the same edge with six bytes queued.
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            idle_step();
            seen = bus.mem_req && (q_count == CW'(6));
        end
        check("wc_setup", 64'(seen), 64'(1));
        idle_step();
        step(1'b0, '0, 2);
        check("wc_count", 64'(q_count), 64'(8));

        // Random traffic: redirects anywhere (including near the top of memory).
        junk_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit            fl;
            logic [AW-1:0] fa;
            int            cons;
            if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(0, 3));
            fetch_en = ($urandom_range(0, 9) != 0);
            fl       = ($urandom_range(0, 29) == 0);
            fa       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            lim      = (mq.size() < 8) ? mq.size() : 8;
            cons     = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, lim));
            step(fl, fa, cons);
        end

        // Reset pulsed mid-transaction: everything clears at once.
        junk_en  = 1'b0;
        fetch_en = 1'b1;
        lat      = 2;
        seen     = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            idle_step();
            seen = bus.mem_req;
        end
        check("mr_setup", 64'(seen), 64'(1));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_mem_req", 64'(bus.mem_req), 64'(0));
        check("mr_q_count", 64'(q_count), 64'(0));
        check("mr_q_pc", 64'(q_pc), 64'(0));
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issues.delete();
        for (int i = 0; i < 10 && issues.size() == 0; i++) idle_step();
        check("mr_first_addr", 64'(issues.size() > 0 ? issues[0] : '1), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
